// File: rtl/led_ripple_monitor_if.sv
// Link between the LED ripple driver (master) and the ripple monitor (slave):
// the sampled LED vector plus the status the monitor reports back.
interface led_ripple_monitor_if;
  logic [7:0]  led;
  logic [2:0]  pos;
  logic        dir;
  logic        valid;
  logic        step;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] step_count;

  modport master (
    output led,
    input  pos, dir, valid, step, err, err_code, step_count
  );

  modport slave (
    input  led,
    output pos, dir, valid, step, err, err_code, step_count
  );
endinterface

// File: rtl/led_ripple_monitor.sv
// Receive-side checker for the rippling LED bus: locks onto the one-hot
// pattern, tracks position/direction and flags shape, step and dwell errors.
module led_ripple_monitor #(
  parameter int SHIFT_TIME = 5,
  parameter bit MODE       = 1'b0  // 0 = rotate with wrap, 1 = bounce at the ends
) (
  input logic                 clk,
  input logic                 rst_n,
  led_ripple_monitor_if.slave bus
);

  localparam int              DW        = $clog2(SHIFT_TIME + 2);
  localparam logic [DW-1:0]   DWELL_REQ = DW'(SHIFT_TIME);
  localparam logic [DW-1:0]   DWELL_MAX = DW'(SHIFT_TIME + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_TRACK,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    E_NONE   = 2'b00,
    E_ONEHOT = 2'b01,
    E_STEP   = 2'b10,
    E_TIMING = 2'b11
  } err_code_t;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  state_t      state, state_d;
  err_code_t   code_r, code_d;
  logic [7:0]  led_q, led_p;
  logic [DW-1:0] dwell;
  logic [2:0]  pos_r;
  logic        dir_r;
  logic        step_r;
  logic        err_r;
  logic [15:0] count_r;

  logic        change;
  logic        q_onehot;
  logic [2:0]  idx_new, idx_old;
  logic        is_up, is_dn;
  logic        at_end;
  logic        track_ok;
  logic        legal;

  assign change   = (led_q != led_p);
  assign q_onehot = is_onehot(led_q);
  assign idx_new  = encode(led_q);
  assign idx_old  = encode(led_p);

  // 3-bit arithmetic wraps mod 8 on its own; bounce mode masks the wrap out.
  assign is_up = (idx_new == idx_old + 3'd1) && (!MODE || idx_old != 3'd7);
  assign is_dn = (idx_new == idx_old - 3'd1) && (!MODE || idx_old != 3'd0);

  // At a bounce end only one neighbour exists, so that move is the forced reversal.
  assign at_end   = MODE && (idx_old == 3'd7 || idx_old == 3'd0);
  assign track_ok = at_end ? (is_up || is_dn) : (dir_r ? is_dn : is_up);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and the process order does not matter.
    if (!rst_n) begin
      state <= S_IDLE;
      led_q <= 8'h00;
      led_p <= 8'h00;
      dwell <= '0;
    end else begin
      state <= state_d;
      led_q <= bus.led;
      led_p <= led_q;
      if (change) begin
        dwell <= DW'(1);
      end else if (dwell != DWELL_MAX) begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state;
    code_d  = E_NONE;
    legal   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (q_onehot) begin
          state_d = S_ACQUIRE;
        end else if (led_q != 8'h00) begin
          code_d = E_ONEHOT;
        end
      end

      // The first move comes after a partial dwell, so only its shape is checked.
      S_ACQUIRE: begin
        if (!q_onehot) begin
          code_d = E_ONEHOT;
        end else if (change) begin
          if (is_up || is_dn) legal  = 1'b1;
          else                code_d = E_STEP;
        end
      end

      S_TRACK: begin
        if (!q_onehot) begin
          code_d = E_ONEHOT;
        end else if (change) begin
          if (!track_ok)               code_d = E_STEP;
          else if (dwell != DWELL_REQ) code_d = E_TIMING;
          else                         legal  = 1'b1;
        end else if (dwell >= DWELL_REQ) begin
          code_d = E_TIMING;
        end
      end

      S_ERROR: begin
        state_d = S_ERROR;
      end
    endcase

    if (code_d != E_NONE) begin
      state_d = S_ERROR;
    end else if (legal) begin
      state_d = S_TRACK;
    end
  end

  // Reported status; nothing here moves once the ERROR state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_r   <= 3'd0;
      dir_r   <= 1'b0;
      step_r  <= 1'b0;
      err_r   <= 1'b0;
      code_r  <= E_NONE;
      count_r <= 16'd0;
    end else begin
      step_r <= legal;
      if (state != S_ERROR && state_d == S_ERROR) begin
        err_r  <= 1'b1;
        code_r <= code_d;
      end
      if (legal) begin
        dir_r <= is_dn;
        if (count_r != 16'hFFFF) count_r <= count_r + 16'd1;
      end
      if (state_d == S_ACQUIRE || state_d == S_TRACK) begin
        pos_r <= idx_new;
      end
    end
  end

  assign bus.pos        = pos_r;
  assign bus.dir        = dir_r;
  assign bus.valid      = (state == S_TRACK);
  assign bus.step       = step_r;
  assign bus.err        = err_r;
  assign bus.err_code   = code_r;
  assign bus.step_count = count_r;

endmodule

// File: tb/tb_led_ripple_monitor.sv
// Directed bench for led_ripple_monitor: one rotate-mode and one bounce-mode
// instance, driven with hand-built LED sequences and hand-computed expectations.
module tb_led_ripple_monitor;

  localparam int SHIFT_TIME = 5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  led_ripple_monitor_if rot_if ();
  led_ripple_monitor_if bnc_if ();

  led_ripple_monitor #(.SHIFT_TIME(SHIFT_TIME), .MODE(1'b0)) u_rot (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rot_if.slave)
  );

  led_ripple_monitor #(.SHIFT_TIME(SHIFT_TIME), .MODE(1'b1)) u_bnc (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bnc_if.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit bnc, input logic [7:0] v);
    if (bnc) bnc_if.led = v;
    else     rot_if.led = v;
  endtask

  task automatic expect_out(input string tag, input bit bnc,
                            input logic [2:0] pos, input logic dir,
                            input logic valid, input logic step,
                            input logic err, input logic [1:0] code,
                            input logic [15:0] cnt);
    logic [2:0]  p;
    logic        d, v, s, e;
    logic [1:0]  c;
    logic [15:0] n;
    if (bnc) begin
      p = bnc_if.pos; d = bnc_if.dir; v = bnc_if.valid; s = bnc_if.step;
      e = bnc_if.err; c = bnc_if.err_code; n = bnc_if.step_count;
    end else begin
      p = rot_if.pos; d = rot_if.dir; v = rot_if.valid; s = rot_if.step;
      e = rot_if.err; c = rot_if.err_code; n = rot_if.step_count;
    end
    check({tag, ".pos"},        32'(p), 32'(pos));
    check({tag, ".dir"},        32'(d), 32'(dir));
    check({tag, ".valid"},      32'(v), 32'(valid));
    check({tag, ".step"},       32'(s), 32'(step));
    check({tag, ".err"},        32'(e), 32'(err));
    check({tag, ".err_code"},   32'(c), 32'(code));
    check({tag, ".step_count"}, 32'(n), 32'(cnt));
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    rot_if.led = 8'h00;
    bnc_if.led = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic hold(input bit bnc, input logic [7:0] v, input int n);
    drive(bnc, v);
    tick(n);
  endtask

  // One legal move held for exactly SHIFT_TIME cycles: result visible 2 edges
  // after the LED change, step gone one edge later.
  task automatic step_and_check(input bit bnc, input logic [7:0] v,
                                input logic [2:0] pos, input logic dir,
                                input logic [15:0] cnt, input logic early_valid,
                                input string tag);
    drive(bnc, v);
    tick(1);
    check({tag, ".valid_early"}, 32'(bnc ? bnc_if.valid : rot_if.valid), 32'(early_valid));
    tick(1);
    expect_out(tag, bnc, pos, dir, 1'b1, 1'b1, 1'b0, 2'b00, cnt);
    tick(1);
    check({tag, ".step_off"}, 32'(bnc ? bnc_if.step : rot_if.step), 32'd0);
    tick(SHIFT_TIME - 3);
  endtask

  logic [7:0] bnc_led [10] = '{8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [2:0] bnc_pos [10] = '{3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
  logic       bnc_dir [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values on both instances while reset is held.
    rst_n      = 1'b0;
    rot_if.led = 8'h00;
    bnc_if.led = 8'h00;
    tick(2);
    expect_out("rst_rot", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);
    expect_out("rst_bnc", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);

    // All-zero LEDs in IDLE are not an error.
    rst_n = 1'b1;
    tick(50);
    expect_out("idle_zero", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);

    // Rotate: 0x01 then 20 left rotations with a 5-cycle dwell.
    hold(1'b0, 8'h01, SHIFT_TIME);
    expect_out("acquire", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);
    for (int i = 1; i <= 20; i++) begin
      step_and_check(1'b0, 8'(1 << (i % 8)), 3'(i % 8), 1'b0, 16'(i),
                     (i > 1), $sformatf("rot_step%0d", i));
    end

    // Stall: 0x10 held past its dwell.
    tick(1);
    check("stall_pre.err", 32'(rot_if.err), 32'd0);
    tick(1);
    expect_out("stall", 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 16'd20);
    hold(1'b0, 8'h03, 3);
    expect_out("err_frozen", 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 16'd20);

    // Reset out of ERROR clears outputs immediately, then a clean re-lock.
    rst_n      = 1'b0;
    rot_if.led = 8'h00;
    #1;
    expect_out("async_rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    hold(1'b0, 8'h80, SHIFT_TIME);
    step_and_check(1'b0, 8'h01, 3'd0, 1'b0, 16'd1, 1'b0, "relock_wrap");
    step_and_check(1'b0, 8'h02, 3'd1, 1'b0, 16'd2, 1'b1, "relock_step2");

    // Early change after 4 cycles in TRACK.
    do_reset();
    hold(1'b0, 8'h01, SHIFT_TIME);
    step_and_check(1'b0, 8'h02, 3'd1, 1'b0, 16'd1, 1'b0, "early_s1");
    step_and_check(1'b0, 8'h04, 3'd2, 1'b0, 16'd2, 1'b1, "early_s2");
    hold(1'b0, 8'h08, 4);
    hold(1'b0, 8'h10, 1);
    check("early_pre.err", 32'(rot_if.err), 32'd0);
    tick(1);
    expect_out("early", 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 16'd3);

    // Not one-hot while tracking.
    do_reset();
    hold(1'b0, 8'h01, SHIFT_TIME);
    step_and_check(1'b0, 8'h02, 3'd1, 1'b0, 16'd1, 1'b0, "onehot_s1");
    hold(1'b0, 8'h03, 2);
    expect_out("track_onehot", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'd1);

    // Not one-hot (and not zero) in IDLE.
    do_reset();
    hold(1'b0, 8'h05, 2);
    expect_out("idle_onehot", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 16'd0);

    // Two-position jump during acquisition.
    do_reset();
    hold(1'b0, 8'h01, SHIFT_TIME);
    hold(1'b0, 8'h04, 2);
    expect_out("jump", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 16'd0);

    // Reversal in rotate mode.
    do_reset();
    hold(1'b0, 8'h02, SHIFT_TIME);
    step_and_check(1'b0, 8'h04, 3'd2, 1'b0, 16'd1, 1'b0, "rev_s1");
    hold(1'b0, 8'h02, 2);
    expect_out("reversal", 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 16'd1);

    // Bounce: up to 7, down to 0, back up.
    do_reset();
    hold(1'b1, 8'h20, SHIFT_TIME);
    for (int i = 0; i < 10; i++) begin
      step_and_check(1'b1, bnc_led[i], bnc_pos[i], bnc_dir[i], 16'(i + 1),
                     (i > 0), $sformatf("bnc_step%0d", i + 1));
    end

    // Bounce: acquisition at index 7 must go down.
    do_reset();
    hold(1'b1, 8'h80, SHIFT_TIME);
    step_and_check(1'b1, 8'h40, 3'd6, 1'b1, 16'd1, 1'b0, "bnc_acq_top");

    // Bounce: 7 -> 0 wrap is illegal.
    do_reset();
    hold(1'b1, 8'h20, SHIFT_TIME);
    step_and_check(1'b1, 8'h40, 3'd6, 1'b0, 16'd1, 1'b0, "bnc_wrap_s1");
    step_and_check(1'b1, 8'h80, 3'd7, 1'b0, 16'd2, 1'b1, "bnc_wrap_s2");
    hold(1'b1, 8'h01, 2);
    expect_out("bnc_wrap", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 16'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_ripple_monitor.md
# led_ripple_monitor

Receive-side checker for the rippling LED bus. It samples the 8-bit `led` vector produced by the LED ripple driver and decodes the lit position and ripple direction. It verifies that the pattern stays one-hot, moves one position per step, and dwells exactly `SHIFT_TIME` cycles per position. Any violation raises a sticky error with a cause code. It sits on the same clock as the driver, either in the bench or on-chip as a self-test observer.

## Interface
- `SHIFT_TIME`, 5: required dwell in clock cycles per LED position (≥2).
- `MODE`, 0: 0 = rotate (7→0 / 0→7 wrap, no reversal); 1 = bounce (reversal only at ends, no wrap).

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `led`  in  8  LED vector from the ripple driver.
- `pos`  out  3  index of the lit bit, valid when `valid`=1.
- `dir`  out  1  0 = moving toward MSB, 1 = toward LSB.
- `valid`  out  1  high in TRACK state (pattern locked).
- `step`  out  1  one-cycle pulse per legal position change.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  01 not one-hot, 10 illegal step, 11 timing; 00 when no error.
- `step_count`  out  16  legal steps counted, saturates at 0xFFFF.

## Operation
- Input stage: `led` is registered into `led_q`, and `led_q` is registered into `led_p`. A change means `led_q != led_p`. All checks use these two registers.
- Dwell counter:
  - Set to 1 on a change; otherwise increments each cycle.
  - Saturates at `SHIFT_TIME+1`.
- States:
  - IDLE: entered from reset.
  - IDLE→ACQUIRE when `led_q` is one-hot.
  - `led_q` = 0 keeps IDLE with no error.
  - Any other non-one-hot value in IDLE → ERROR, code 01.
- ACQUIRE:
  - Waits for the first change. No timing check on this step (partial dwell).
  - A legal step sets `dir`, pulses `step`, increments `step_count`, and moves to TRACK.
- TRACK:
  - Every change must be a legal step.
  - Every change must occur with dwell == `SHIFT_TIME`.
  - If dwell reaches `SHIFT_TIME` and there is still no change on the next cycle → ERROR, code 11 (stall).
  - A change with dwell < `SHIFT_TIME` → ERROR, code 11 (early).
- Legal step in rotate mode: new index = old ±1 mod 8, with the sign matching `dir`. In ACQUIRE either sign is accepted.
- Legal step in bounce mode:
  - New index = old ±1 with no wrap.
  - The sign must match `dir`, except at index 7 (must go down, `dir`←1) and index 0 (must go up, `dir`←0).
  - In ACQUIRE, index 7 forces down and index 0 forces up.
- In ACQUIRE/TRACK:
  - `led_q` not one-hot (including all-zero) → code 01.
  - One-hot but illegal position → code 10.
- Error priority on a single cycle: 01 > 10 > 11.
- ERROR state:
  - Absorbing; exits only via `rst_n`.
  - `valid`=0, `step`=0, `err`=1.
  - `err_code`, `pos`, `dir` and `step_count` are frozen at the values they had when the error was detected.
- `pos` tracks the decoded index of `led_q` in ACQUIRE and TRACK.

## Timing
- Reset (async assert, synchronous release at next edge): state IDLE, `led_q`=`led_p`=0, dwell=0, `pos`=0, `dir`=0, `valid`=0, `step`=0, `err`=0, `err_code`=00, `step_count`=0.
- Latency: a change on `led` before edge k is in `led_q` after k and is compared at k+1. `step`, `pos`, `dir`, `err`, `err_code`, `step_count` and `valid` are registered and update after edge k+1, i.e. 2 cycles of latency.
- `step` is high for exactly one cycle per legal step and is never high together with a new `err`.
- Early/stall detection fires on the same edge the offending change (or missing change) is seen.
- Reset asserted mid-TRACK or in ERROR clears everything immediately. The monitor re-acquires from IDLE.

## Test plan
- Rotate, `SHIFT_TIME`=5, drive 0x01 then rotate left every 5 cycles for 20 steps → `valid` rises 2 cycles after the first change, `step` pulses every 5 cycles, `pos` 1,2,…,7,0,1…, `dir`=0, `step_count`=20, `err`=0.
- Rotate, change after 4 cycles in TRACK → `err`=1, `err_code`=11, `valid`=0, `step_count` frozen. Separately, hold for 6 cycles → `err_code`=11.
- Drive 0x03 in TRACK → `err_code`=01. Drive 0x00 in IDLE for 50 cycles → `err`=0, `valid`=0.
- Rotate, step 0x01→0x04 → `err_code`=10. Step 0x02→0x04→0x02 → `err_code`=10 on the reversal.
- Bounce, `MODE`=1, 5-cycle dwell: 0x20→0x40→0x80→0x40→…→0x01→0x02 → no error, `dir` flips to 1 at index 7 and to 0 at index 0. A 0x80→0x01 wrap → `err_code`=10.
- In ERROR, assert `rst_n`=0 for 1 cycle, then replay a clean ripple → all outputs at reset values, then normal lock with `step_count` restarting from 0.
